// File: rtl/lsu_pkg.sv
// Shared load-store-unit definitions: size codes, byte counts and the
// datapath-width legality check used by the load alignment pipeline.
package lsu_pkg;

    // Access size codes as presented on the request size field.
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Number of bytes moved by a given size code (only meaningful for codes 0..3).
    function automatic int unsigned size_bytes(input int unsigned sz);
        return 32'd1 << sz;
    endfunction

    // Only 32- and 64-bit datapaths are supported.
    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Number of legal size codes for a datapath: byte/half/word, plus dword on 64-bit.
    function automatic int num_sizes(input int xlen);
        return (xlen == 64) ? 4 : 3;
    endfunction

endpackage

// File: rtl/ext_lane.sv
// One extension lane: takes the low W bits of the aligned word and widens
// them to XLEN, sign- or zero-filling the upper bits. A lane as wide as the
// datapath is a plain pass-through and ignores the sign-extend request.
module ext_lane #(
    parameter int XLEN = 32,
    parameter int W    = 8
) (
    input  logic [W-1:0]    i_field,
    input  logic            i_sext,
    output logic [XLEN-1:0] o_data
);

    generate
        if (W >= XLEN) begin : g_pass
            logic w_unused_sext;
            assign w_unused_sext = i_sext;
            assign o_data        = i_field[XLEN-1:0];
        end else begin : g_ext
            logic w_fill;
            assign w_fill = i_sext & i_field[W-1];
            assign o_data = {{(XLEN-W){w_fill}}, i_field};
        end
    endgenerate

endmodule

// File: rtl/load_align_ext.sv
// Load data alignment and extension, two-stage valid/ready pipeline.
// S1 captures the request already shifted down by the byte offset together
// with its size, sign flag and error status; S2 captures the size-masked,
// extended result. Both stages hold under backpressure and refill in the
// same cycle they drain.
module load_align_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SZ_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_data,
    input  logic [$clog2(XLEN/8)-1:0] in_offset,
    input  logic [SZ_W-1:0]           in_size,
    input  logic                      in_sext,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data,
    output logic                      out_err
);

    localparam int OFF_W   = $clog2(XLEN/8);
    localparam int NSZ     = num_sizes(XLEN);
    localparam bit XLEN_OK = xlen_legal(XLEN);

    // Stage 1 state
    logic              r_v1;
    logic [XLEN-1:0]   r_data1;
    logic [SZ_W-1:0]   r_size1;
    logic              r_sext1;
    logic              r_err1;

    // Stage 2 state
    logic              r_v2;
    logic [XLEN-1:0]   r_out_data;
    logic              r_out_err;

    logic              w_ready1;
    logic              w_ready2;
    logic              w_illegal;
    logic              w_misalign;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_result;
    logic [XLEN-1:0]   w_lane [NSZ];

    // A stage can take a new entry when empty or when its content leaves this cycle.
    assign w_ready2  = !r_v2 | out_ready;
    assign w_ready1  = !r_v1 | w_ready2;
    // Held low during reset; otherwise purely a function of stage state and out_ready.
    assign in_ready  = rst_n & w_ready1;

    assign w_shifted = in_data >> {in_offset, 3'b000};

    // Classify the incoming request: unknown size code or offset not size-aligned.
    always_comb begin
        w_illegal  = !XLEN_OK || (int'(in_size) >= NSZ);
        w_misalign = 1'b0;
        if (!w_illegal) begin
            w_misalign = ((int'(in_offset) & (int'(size_bytes(int'(in_size))) - 1)) != 0);
        end
    end

    // Valid bits and the output register; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            if (w_ready1) begin
                r_v1 <= in_valid;
            end
            if (w_ready2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_out_data <= w_result;
                    r_out_err  <= r_err1;
                end
            end
        end
    end

    // Stage 1 payload: loaded on accept, held otherwise; no reset needed.
    always_ff @(posedge clk) begin
        if (w_ready1 && in_valid) begin
            r_data1 <= w_shifted;
            r_size1 <= in_size;
            r_sext1 <= in_sext;
            r_err1  <= w_illegal | w_misalign;
        end
    end

    // One extension lane per legal size: 8, 16, 32 and (on 64-bit) 64 bits.
    genvar gi;
    generate
        for (gi = 0; gi < NSZ; gi++) begin : g_lane
            localparam int W = 8 << gi;
            ext_lane #(
                .XLEN (XLEN),
                .W    (W)
            ) u_lane (
                .i_field (r_data1[W-1:0]),
                .i_sext  (r_sext1),
                .o_data  (w_lane[gi])
            );
        end
    endgenerate

    // Pick the lane matching the size; errored requests produce all-zero data.
    always_comb begin
        w_result = '0;
        for (int k = 0; k < NSZ; k++) begin
            if (int'(r_size1) == k) begin
                w_result = w_lane[k];
            end
        end
        if (r_err1) begin
            w_result = '0;
        end
    end

    assign out_valid = r_v2;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_load_align_ext.sv
// Self-checking bench for load_align_ext: a 32-bit and a 64-bit instance.
// Stimulus pushes expected {err,data} into per-instance queues at accept;
// a monitor pops and compares on every output handshake.
module tb_load_align_ext;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        a_in_valid, a_in_ready, a_in_sext;
    logic [31:0] a_in_data;
    logic [1:0]  a_in_offset, a_in_size;
    logic        a_out_valid, a_out_ready, a_out_err;
    logic [31:0] a_out_data;

    // 64-bit instance signals
    logic        b_in_valid, b_in_ready, b_in_sext;
    logic [63:0] b_in_data;
    logic [2:0]  b_in_offset;
    logic [1:0]  b_in_size;
    logic        b_out_valid, b_out_ready, b_out_err;
    logic [63:0] b_out_data;

    load_align_ext #(.XLEN(32), .SZ_W(2)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_offset (a_in_offset),
        .in_size   (a_in_size),
        .in_sext   (a_in_sext),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_err   (a_out_err)
    );

    load_align_ext #(.XLEN(64), .SZ_W(2)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_offset (b_in_offset),
        .in_size   (b_in_size),
        .in_sext   (b_in_sext),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_err   (b_out_err)
    );

    logic [32:0] q_a[$];
    logic [64:0] q_b[$];
    int checks   = 0;
    int failures = 0;

    // Streaming vectors, all on data 0x8899AABB.
    localparam logic [1:0]  TV_OFF [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
    localparam logic [1:0]  TV_SZ  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
    localparam logic        TV_SX  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] TV_ED  [8] = '{32'h000000BB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'h00000088,
                                           32'hFFFFAABB, 32'h00008899, 32'h8899AABB, 32'h00000000};
    localparam logic        TV_EE  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    task automatic send_a(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                          input logic sx, input logic [31:0] ed, input logic ee);
        int n;
        n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_offset = off; a_in_size = sz; a_in_sext = sx;
        forever begin
            @(negedge clk);
            if (a_in_ready) begin
                q_a.push_back({ee, ed});
                break;
            end
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL send_a_timeout got=in_ready_low expected=accept");
                break;
            end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input logic sx, input logic [63:0] ed, input logic ee);
        int n;
        n = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_offset = off; b_in_size = sz; b_in_sext = sx;
        forever begin
            @(negedge clk);
            if (b_in_ready) begin
                q_b.push_back({ee, ed});
                break;
            end
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL send_b_timeout got=in_ready_low expected=accept");
                break;
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drive_vec(input int i);
        a_in_data = 32'h8899AABB; a_in_offset = TV_OFF[i]; a_in_size = TV_SZ[i]; a_in_sext = TV_SX[i];
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_a", 65'(q_a.size()), 65'd0);
        check("drain_b", 65'(q_b.size()), 65'd0);
    endtask

    // Monitor: compare each handshaked output with the queue head; check stability under stall.
    initial begin
        logic        hold_v;
        logic [32:0] hold;
        logic [32:0] ea;
        logic [64:0] eb;
        hold_v = 1'b0;
        hold   = '0;
        forever begin
            @(negedge clk);
            if (a_out_valid) begin
                if (hold_v) check("a_stable", {32'b0, a_out_err, a_out_data}, {32'b0, hold});
                if (a_out_ready) begin
                    hold_v = 1'b0;
                    if (q_a.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL a_unexpected got=%h expected=no_output", {a_out_err, a_out_data});
                    end else begin
                        ea = q_a.pop_front();
                        check("a_result", {32'b0, a_out_err, a_out_data}, {32'b0, ea});
                    end
                end else begin
                    hold_v = 1'b1;
                    hold   = {a_out_err, a_out_data};
                end
            end else begin
                hold_v = 1'b0;
            end
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected got=%h expected=no_output", {b_out_err, b_out_data});
                end else begin
                    eb = q_b.pop_front();
                    check("b_result", {b_out_err, b_out_data}, eb);
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int acc;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_offset = '0; a_in_size = '0; a_in_sext = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_offset = '0; b_in_size = '0; b_in_sext = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 65'(a_out_valid), 65'd0);
        check("rst_in_ready", 65'(a_in_ready), 65'd0);
        check("rst_out_data", 65'(a_out_data), 65'd0);
        check("rst_b_in_ready", 65'(b_in_ready), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 65'(a_in_ready), 65'd1);

        // Byte at offset 1, sign-extended; output registered on the edge after accept.
        send_a(32'h8899AABB, 2'd1, 2'd0, 1'b1, 32'hFFFFFFAA, 1'b0);
        check("lat_not_yet", 65'(a_out_valid), 65'd0);
        @(posedge clk); #1;
        check("lat_valid", 65'(a_out_valid), 65'd1);

        // Half at offset 2, zero then sign extension.
        send_a(32'h80FF1234, 2'd2, 2'd1, 1'b0, 32'h000080FF, 1'b0);
        send_a(32'h80FF1234, 2'd2, 2'd1, 1'b1, 32'hFFFF80FF, 1'b0);
        // Misaligned and illegal-size requests.
        send_a(32'h80FF1234, 2'd3, 2'd1, 1'b1, 32'h00000000, 1'b1);
        send_a(32'h80FF1234, 2'd2, 2'd2, 1'b0, 32'h00000000, 1'b1);
        send_a(32'h80FF1234, 2'd0, 2'd3, 1'b0, 32'h00000000, 1'b1);
        send_a(32'h80FF1234, 2'd0, 2'd2, 1'b1, 32'h80FF1234, 1'b0);
        wait_drain();

        // Stream of 8 with consumer stalled for the first 5 cycles.
        a_out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            drive_vec(idx);
            a_in_valid = 1'b1;
            @(negedge clk);
            if (a_in_ready) begin
                q_a.push_back({TV_EE[idx], TV_ED[idx]});
                idx++;
                acc++;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        check("bp_accepts", 65'(acc), 65'd2);
        check("bp_in_ready_low", 65'(a_in_ready), 65'd0);
        a_out_ready = 1'b1;
        while (idx < 8) begin
            send_a(32'h8899AABB, TV_OFF[idx], TV_SZ[idx], TV_SX[idx], TV_ED[idx], TV_EE[idx]);
            idx++;
        end
        wait_drain();

        // Reset with two requests in flight (first one is an error).
        a_out_ready = 1'b0;
        send_a(32'h11223344, 2'd1, 2'd1, 1'b0, 32'h00000000, 1'b1);
        send_a(32'h11223344, 2'd1, 2'd0, 1'b0, 32'h00000033, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 65'(a_out_valid), 65'd0);
        check("arst_out_err", 65'(a_out_err), 65'd0);
        check("arst_out_data", 65'(a_out_data), 65'd0);
        check("arst_in_ready", 65'(a_in_ready), 65'd0);
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        send_a(32'h0000F0F0, 2'd0, 2'd1, 1'b1, 32'hFFFFF0F0, 1'b0);
        wait_drain();

        // 64-bit datapath
        send_b(64'h00000000_80000000, 3'd0, 2'd2, 1'b1, 64'hFFFFFFFF_80000000, 1'b0);
        send_b(64'h01234567_89ABCDEF, 3'd4, 2'd3, 1'b0, 64'h0, 1'b1);
        send_b(64'h01234567_89ABCDEF, 3'd0, 2'd3, 1'b1, 64'h01234567_89ABCDEF, 1'b0);
        send_b(64'h01234567_89ABCDEF, 3'd7, 2'd0, 1'b1, 64'h00000000_00000001, 1'b0);
        send_b(64'h01234567_89ABCDEF, 3'd4, 2'd2, 1'b0, 64'h00000000_01234567, 1'b0);
        send_b(64'h01234567_89ABCDEF, 3'd2, 2'd1, 1'b1, 64'hFFFFFFFF_FFFF89AB, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
